mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Single-port memory controller between the out-of-order core and the byte-wide unified RAM. It arbitrates between instruction fetch and the load/store buffer, and serialises each 1/2/4-byte access into per-byte RAM cycles. It assembles and sign- or zero-extends load data, and returns one completion pulse per accepted request. All RAM traffic in the core passes through this block.

## Interface
- No parameters; type encodings and IO constants come from the shared package.
- clk_in  in  1  system clock. One clock; reset is asynchronous and active-low.
- rst_in  in  1  asynchronous, active-low reset.
- rdy_in  in  1  global ready; low freezes all state.
- clear  in  1  pipeline flush (branch mispredict).
- if_enable  in  1  fetch request, level, held until if_done.
- if_addr  in  32  fetch address.
- if_done  out  1  one-cycle pulse; if_data valid.
- if_data  out  32  fetched word, little-endian.
- ls_enable  in  1  LSB request, level.
- addr  in  32  LSB effective address.
- store_val  in  32  store data.
- lsb_type  in  4  access type: bit3 = store, bit2 = unsigned, [1:0] = size (00 byte, 01 half, 10 word).
- ls_finished  out  1  one-cycle pulse; load_val valid.
- load_val  out  32  extended load result; 0 for stores.
- mem_din  in  8  RAM read byte for the previous cycle's mem_a.
- mem_dout  out  8  RAM write byte.
- mem_a  out  32  RAM byte address.
- mem_wr  out  1  1 = write.
- io_buffer_full  in  1  UART FIFO full.

## Operation
- FSM states:
  - IDLE: sample requests, grant, latch addr/type/data, set byte counter cnt = 0.
  - READ: mem_a = base+cnt while cnt < n. Capture mem_din into byte cnt−1 of the shift register. After the last byte is captured, pulse done and return to IDLE.
  - WRITE: mem_wr = 1, mem_a = base+cnt, mem_dout = byte cnt of store_val. After n bytes, pulse done and return to IDLE.
- Byte count n: byte 1, half 2, word 4. Fetch is always 4 bytes, unsigned.
- Grant on conflict goes to the requester not granted last. last_grant resets to IF, so the LSB wins the first conflict. Under sustained conflict, grants alternate.
- Extension: signed types replicate bit 7 or bit 15; unsigned types zero-fill.
- IO store stall: a store with addr[17:16] == 2'b11 is not accepted while io_buffer_full = 1. The block stays in IDLE with mem_wr = 0 and re-samples every cycle. The IF request may be granted meanwhile.
- clear:
  - Requests sampled in the clear cycle are ignored.
  - An in-flight READ (fetch or load) aborts to IDLE, with no done pulse and mem_wr = 0.
  - An in-flight WRITE is committed; it always completes and pulses ls_finished.
- rdy_in low: all registers hold, and mem_wr is driven 0.
- Reset values: IDLE, mem_a = 0, mem_dout = 0, mem_wr = 0, if_done = 0, ls_finished = 0, if_data = 0, load_val = 0, cnt = 0, last_grant = IF.

## Timing
- Request accepted in IDLE at cycle T.
- Read of n bytes:
  - mem_a = base..base+n−1 during T+1..T+n.
  - Bytes captured during T+2..T+n+1.
  - Done pulse and data valid in cycle T+n+2. LW: ls_finished in T+6.
- Write of n bytes:
  - mem_wr = 1 during T+1..T+n only.
  - Done pulse in T+n+1.
- The done cycle is an IDLE cycle. A request present in that cycle is accepted, giving back-to-back access with no bubble. A requester must update its request combinationally on its own done pulse.
- Done pulses are never asserted twice for one request. if_done and ls_finished are never high in the same cycle.
- Address arithmetic is 32-bit and wraps modulo 2^32.

## Structure
- Shared package: lsb_type encodings (LB 0000, LH 0001, LW 0010, LBU 0100, LHU 0101, SB 1000, SH 1001, SW 1010), IO address-decode constant, FSM state encoding.
- One sub-module: mem_load_ext (combinational size/sign extension of the 32-bit assembled data).
- The arbiter stays inline.

## Test plan
- LW at 0x100, RAM bytes 78 56 34 12 -> ls_finished in T+6, load_val = 0x12345678, mem_wr = 0 throughout.
- LB with byte 0x80 -> 0xFFFFFF80. LBU with the same byte -> 0x00000080. LH with bytes 01 80 -> 0xFFFF8001.
- SH of 0xDEADBEEF to 0x200 -> mem_wr = 1 in T+1..T+2, mem_a 0x200/0x201, mem_dout EF/BE, ls_finished in T+3, load_val = 0.
- if_enable and ls_enable both held from reset -> first grant LSB, then IF, then alternating. Each done cycle accepts the next request with no bubble.
- clear in T+2 of a fetch -> no if_done, IDLE next cycle. clear in T+2 of an SW -> all 4 bytes written, ls_finished in T+5.
- SW to 0x30000 with io_buffer_full high for 3 cycles -> mem_wr stays 0, accepted in the cycle it drops. rdy_in low for 2 cycles mid-LW -> mem_a and cnt hold, result still 0x12345678 two cycles later.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the memory controller: access types, IO decode and FSM states.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } mc_state_e;

  typedef enum logic {
    GRANT_IF = 1'b0,
    GRANT_LS = 1'b1
  } grant_e;

  localparam logic [3:0] LSB_LB  = 4'b0000;
  localparam logic [3:0] LSB_LH  = 4'b0001;
  localparam logic [3:0] LSB_LW  = 4'b0010;
  localparam logic [3:0] LSB_LBU = 4'b0100;
  localparam logic [3:0] LSB_LHU = 4'b0101;
  localparam logic [3:0] LSB_SB  = 4'b1000;
  localparam logic [3:0] LSB_SH  = 4'b1001;
  localparam logic [3:0] LSB_SW  = 4'b1010;

  // addr[17:16] value that selects the UART window
  localparam logic [1:0] IO_ADDR_SEL = 2'b11;

  function automatic logic [2:0] byte_count(input logic [1:0] size);
    case (size)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Size/sign extension of an assembled little-endian load word.
module mem_load_ext (
  input  logic [31:0] raw,
  input  logic [2:0]  lsb_type,
  output logic [31:0] ext
);

  logic sgn;

  always_comb begin
    sgn = ~lsb_type[2];
    ext = raw;
    case (lsb_type[1:0])
      2'b00:   ext = {{24{sgn & raw[7]}}, raw[7:0]};
      2'b01:   ext = {{16{sgn & raw[15]}}, raw[15:0]};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// Fetch/LSB arbiter that serialises 1/2/4-byte accesses onto the byte-wide RAM.
// Handshake: a request is a level held until its own one-cycle done pulse; it is accepted in an IDLE cycle.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear,
  input  logic        if_enable,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        ls_enable,
  input  logic [31:0] addr,
  input  logic [31:0] store_val,
  input  logic [3:0]  lsb_type,
  output logic        ls_finished,
  output logic [31:0] load_val,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  mc_state_e   state_q, state_d;
  grant_e      last_grant_q;
  logic [2:0]  cnt_q, n_q;
  logic [2:0]  type_q;
  logic        is_fetch_q;
  logic [31:0] wdata_q, rbuf_q, mem_a_q, if_data_q, load_val_q;
  logic [7:0]  mem_dout_q, din_q;
  logic        mem_wr_q, if_done_q, ls_finished_q, rdy_q;

  logic        ls_is_store, io_stall, ls_req, grant_ls, grant_if, accept;
  logic [1:0]  cap_idx;
  logic [7:0]  din_eff;
  logic [31:0] assembled, ext_val;

  always_comb begin
    ls_is_store = lsb_type[3];
    io_stall    = ls_is_store && (addr[17:16] == IO_ADDR_SEL) && io_buffer_full;
    ls_req      = ls_enable && !io_stall;
    grant_ls    = ls_req && (!if_enable || last_grant_q == GRANT_IF);
    grant_if    = if_enable && !grant_ls;
    accept      = (state_q == ST_IDLE) && !clear && (grant_ls || grant_if);
  end

  // The RAM keeps answering during a freeze, so the byte owed to the frozen cycle is parked.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rdy_q <= 1'b1;
      din_q <= 8'd0;
    end else begin
      rdy_q <= rdy_in;
      if (!rdy_in && rdy_q) din_q <= mem_din;
    end
  end

  always_comb begin
    din_eff   = rdy_q ? mem_din : din_q;
    cap_idx   = cnt_q[1:0] - 2'd1;
    assembled = rbuf_q;
    assembled[{cap_idx, 3'b000} +: 8] = din_eff;
  end

  mem_load_ext u_ext (
    .raw      (assembled),
    .lsb_type (type_q),
    .ext      (ext_val)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = (grant_ls && ls_is_store) ? ST_WRITE : ST_READ;
      ST_READ:  if (clear || cnt_q == n_q) state_d = ST_IDLE;
      ST_WRITE: if (cnt_q == n_q - 3'd1) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q       <= ST_IDLE;
      last_grant_q  <= GRANT_IF;
      cnt_q         <= 3'd0;
      n_q           <= 3'd0;
      type_q        <= 3'd0;
      is_fetch_q    <= 1'b0;
      wdata_q       <= 32'd0;
      rbuf_q        <= 32'd0;
      mem_a_q       <= 32'd0;
      mem_dout_q    <= 8'd0;
      mem_wr_q      <= 1'b0;
      if_done_q     <= 1'b0;
      ls_finished_q <= 1'b0;
      if_data_q     <= 32'd0;
      load_val_q    <= 32'd0;
    end else if (rdy_in) begin
      state_q       <= state_d;
      if_done_q     <= 1'b0;
      ls_finished_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            cnt_q <= 3'd0;
            if (grant_ls) begin
              last_grant_q <= GRANT_LS;
              is_fetch_q   <= 1'b0;
              type_q       <= lsb_type[2:0];
              n_q          <= byte_count(lsb_type[1:0]);
              mem_a_q      <= addr;
              wdata_q      <= store_val;
              if (ls_is_store) begin
                mem_wr_q   <= 1'b1;
                mem_dout_q <= store_val[7:0];
              end
            end else begin
              last_grant_q <= GRANT_IF;
              is_fetch_q   <= 1'b1;
              type_q       <= LSB_LW[2:0];
              n_q          <= 3'd4;
              mem_a_q      <= if_addr;
            end
          end
        end
        ST_READ: begin
          if (clear) begin
            cnt_q <= 3'd0;
          end else begin
            if (cnt_q != 3'd0) rbuf_q <= assembled;
            if (cnt_q == n_q) begin
              cnt_q <= 3'd0;
              if (is_fetch_q) begin
                if_done_q <= 1'b1;
                if_data_q <= assembled;
              end else begin
                ls_finished_q <= 1'b1;
                load_val_q    <= ext_val;
              end
            end else begin
              cnt_q <= cnt_q + 3'd1;
              if (cnt_q + 3'd1 < n_q) mem_a_q <= mem_a_q + 32'd1;
            end
          end
        end
        ST_WRITE: begin
          // Writes are committed once started; clear is deliberately ignored here.
          if (cnt_q == n_q - 3'd1) begin
            cnt_q         <= 3'd0;
            mem_wr_q      <= 1'b0;
            ls_finished_q <= 1'b1;
            load_val_q    <= 32'd0;
          end else begin
            cnt_q      <= cnt_q + 3'd1;
            mem_a_q    <= mem_a_q + 32'd1;
            mem_dout_q <= wdata_q[15:8];
            wdata_q    <= wdata_q >> 8;
          end
        end
        default: cnt_q <= 3'd0;
      endcase
    end
  end

  assign mem_a       = mem_a_q;
  assign mem_dout    = mem_dout_q;
  assign mem_wr      = mem_wr_q & rdy_in;
  assign if_done     = if_done_q;
  assign if_data     = if_data_q;
  assign ls_finished = ls_finished_q;
  assign load_val    = load_val_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte RAM environment, arithmetic reference model, directed and random accesses.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        clear = 1'b0;
  logic        if_enable = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic        ls_enable = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] store_val = 32'd0;
  logic [3:0]  lsb_type = 4'd0;
  logic        io_buffer_full = 1'b0;
  logic        if_done, ls_finished, mem_wr;
  logic [31:0] if_data, load_val, mem_a;
  logic [7:0]  mem_din, mem_dout;

  typedef struct {
    logic [31:0] a;
    logic [7:0]  d;
    int          c;
  } wr_t;

  logic [31:0] exp_q[$];
  wr_t         wr_q[$];
  logic [7:0]  ram [0:4095];
  logic [7:0]  ref_mem [0:4095];
  logic        bk_we = 1'b0;
  logic [11:0] bk_a = 12'd0;
  logic [7:0]  bk_d = 8'd0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  int          if_done_cnt = 0;
  int          ls_fin_cnt = 0;
  int          fetch_issued = 0;
  int          ls_issued = 0;

  mem_ctrl dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .clear          (clear),
    .if_enable      (if_enable),
    .if_addr        (if_addr),
    .if_done        (if_done),
    .if_data        (if_data),
    .ls_enable      (ls_enable),
    .addr           (addr),
    .store_val      (store_val),
    .lsb_type       (lsb_type),
    .ls_finished    (ls_finished),
    .load_val       (load_val),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .io_buffer_full (io_buffer_full)
  );

  // clock/reset block
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  function automatic logic [7:0] init_byte(input int i);
    return 8'(i * 37 + 11);
  endfunction

  // RAM environment: read data arrives one cycle after the address
  always @(posedge clk_in) begin
    if (!rst_in) begin
      for (int i = 0; i < 4096; i++) ram[i] <= init_byte(i);
    end else if (mem_wr) begin
      ram[mem_a[11:0]] <= mem_dout;
    end else if (bk_we) begin
      ram[bk_a] <= bk_d;
    end
    mem_din <= ram[mem_a[11:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk_in) begin
    if (rst_in) begin
      check("done_excl", {31'd0, if_done & ls_finished}, 32'd0);
      if (!rdy_in) check("wr_frozen", {31'd0, mem_wr}, 32'd0);
      if (mem_wr) wr_q.push_back('{mem_a, mem_dout, cyc});
      if (if_done) if_done_cnt++;
      if (ls_finished) ls_fin_cnt++;
    end
  end

  // Reference: gather n bytes little-endian as a number, then apply two's-complement if signed.
  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [3:0] t);
    int     n;
    longint v;
    n = (t[1:0] == 2'b00) ? 1 : (t[1:0] == 2'b01) ? 2 : 4;
    v = 0;
    for (int i = 0; i < n; i++) v += longint'(ref_mem[12'(a + 32'(i))]) << (8 * i);
    if (!t[2] && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
    return 32'(v);
  endfunction

  function automatic int nbytes(input logic [3:0] t);
    return (t[1:0] == 2'b00) ? 1 : (t[1:0] == 2'b01) ? 2 : 4;
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic poke(input logic [11:0] a, input logic [7:0] d);
    bk_we = 1'b1; bk_a = a; bk_d = d;
    ref_mem[a] = d;
    tick();
    bk_we = 1'b0;
  endtask

  // driver: one LSB access, held until ls_finished, then checked
  task automatic ls_req(input logic [31:0] a, input logic [3:0] t, input logic [31:0] sv,
                        input int exp_lat, input string tag);
    int t0, n;
    bit got;
    n = nbytes(t);
    exp_q.push_back(t[3] ? 32'd0 : ref_load(a, t));
    wr_q.delete();
    addr = a; lsb_type = t; store_val = sv; ls_enable = 1'b1;
    t0 = cyc; got = 1'b0;
    ls_issued++;
    for (int k = 0; k < 40 && !got; k++) begin
      tick();
      if (ls_finished) got = 1'b1;
    end
    ls_enable = 1'b0;
    check({tag, "_done"}, {31'd0, got}, 32'd1);
    check({tag, "_lat"}, 32'(cyc - t0), 32'(exp_lat));
    check({tag, "_val"}, load_val, exp_q.pop_front());
    if (t[3]) begin
      check({tag, "_nwr"}, 32'(wr_q.size()), 32'(n));
      for (int i = 0; i < n && i < wr_q.size(); i++) begin
        check({tag, "_wa"}, wr_q[i].a, a + 32'(i));
        check({tag, "_wd"}, {24'd0, wr_q[i].d}, {24'd0, sv[8*i +: 8]});
        check({tag, "_wc"}, 32'(wr_q[i].c), 32'(t0 + exp_lat - n + i));
        ref_mem[12'(a + 32'(i))] = sv[8*i +: 8];
      end
    end else begin
      check({tag, "_nwr"}, 32'(wr_q.size()), 32'd0);
    end
  endtask

  task automatic fetch_req(input logic [31:0] a, input string tag);
    int t0;
    bit got;
    if_addr = a; if_enable = 1'b1; t0 = cyc; got = 1'b0;
    fetch_issued++;
    for (int k = 0; k < 40 && !got; k++) begin
      tick();
      if (if_done) got = 1'b1;
    end
    if_enable = 1'b0;
    check({tag, "_done"}, {31'd0, got}, 32'd1);
    check({tag, "_lat"}, 32'(cyc - t0), 32'd6);
    check({tag, "_data"}, if_data, ref_load(a, LSB_LW));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    logic [3:0]  types [8];
    logic [3:0]  t;
    logic [31:0] a, exp_if, exp_ls;
    int          t0;
    bit          got;

    types = '{LSB_LB, LSB_LH, LSB_LW, LSB_LBU, LSB_LHU, LSB_SB, LSB_SH, LSB_SW};
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_byte(i);

    // reset values
    repeat (3) @(posedge clk_in);
    #1;
    check("rst_mem_a", mem_a, 32'd0);
    check("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
    check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    check("rst_if_done", {31'd0, if_done}, 32'd0);
    check("rst_ls_fin", {31'd0, ls_finished}, 32'd0);
    check("rst_if_data", if_data, 32'd0);
    check("rst_load_val", load_val, 32'd0);
    @(negedge clk_in);
    rst_in = 1'b1;
    tick();

    // sustained conflict: LSB first, then alternating, no bubble
    exp_if = ref_load(32'h180, LSB_LW);
    exp_ls = ref_load(32'h100, LSB_LW);
    if_addr = 32'h180; addr = 32'h100; lsb_type = LSB_LW;
    if_enable = 1'b1; ls_enable = 1'b1; t0 = cyc;
    for (int g = 0; g < 6; g++) begin
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
        tick();
        if (if_done || ls_finished) got = 1'b1;
      end
      check("alt_done", {31'd0, got}, 32'd1);
      check("alt_gap", 32'(cyc - t0), 32'd6);
      check("alt_who_ls", {31'd0, ls_finished}, {31'd0, (g % 2) == 0});
      if (ls_finished) check("alt_ls_val", load_val, exp_ls);
      else check("alt_if_val", if_data, exp_if);
      t0 = cyc;
    end
    if_enable = 1'b0; ls_enable = 1'b0;
    fetch_issued += 3; ls_issued += 3;
    tick();

    // LW with known bytes
    poke(12'h100, 8'h78); poke(12'h101, 8'h56); poke(12'h102, 8'h34); poke(12'h103, 8'h12);
    ls_req(32'h100, LSB_LW, 32'd0, 6, "lw");
    check("lw_const", load_val, 32'h12345678);

    // extension
    poke(12'h300, 8'h80);
    ls_req(32'h300, LSB_LB, 32'd0, 3, "lb");
    check("lb_const", load_val, 32'hFFFFFF80);
    ls_req(32'h300, LSB_LBU, 32'd0, 3, "lbu");
    check("lbu_const", load_val, 32'h00000080);
    poke(12'h310, 8'h01); poke(12'h311, 8'h80);
    ls_req(32'h310, LSB_LH, 32'd0, 4, "lh");
    check("lh_const", load_val, 32'hFFFF8001);
    ls_req(32'h310, LSB_LHU, 32'd0, 4, "lhu");

    // halfword store
    ls_req(32'h200, LSB_SH, 32'hDEADBEEF, 3, "sh");
    ls_req(32'h200, LSB_LHU, 32'd0, 4, "sh_rd");
    check("sh_rd_const", load_val, 32'h0000BEEF);

    // clear aborts a fetch; the next cycle is IDLE
    tick();
    if_addr = 32'h140; if_enable = 1'b1;
    tick(); check("clr_f_t1", {31'd0, if_done}, 32'd0);
    tick(); clear = 1'b1; if_enable = 1'b0;
    tick(); clear = 1'b0;
    ls_req(32'h100, LSB_LW, 32'd0, 6, "after_clr");

    // clear cannot abort a store
    fork
      ls_req(32'h220, LSB_SW, 32'h01020304, 5, "sw_clr");
      begin tick(); tick(); clear = 1'b1; tick(); clear = 1'b0; end
    join

    // IO store waits for the UART FIFO
    fork
      ls_req(32'h00030000, LSB_SW, 32'hA1B2C3D4, 8, "io_sw");
      begin io_buffer_full = 1'b1; tick(); tick(); tick(); io_buffer_full = 1'b0; end
    join

    // freeze mid-load
    fork
      ls_req(32'h100, LSB_LW, 32'd0, 8, "rdy_lw");
      begin
        tick(); tick(); tick();
        rdy_in = 1'b0;
        check("rdy_a_hold0", mem_a, 32'h102);
        tick();
        check("rdy_a_hold1", mem_a, 32'h102);
        tick();
        rdy_in = 1'b1;
      end
    join
    check("rdy_lw_const", load_val, 32'h12345678);

    // address wrap
    poke(12'hFFF, 8'h34); poke(12'h000, 8'h92);
    fork
      ls_req(32'hFFFFFFFF, LSB_LH, 32'd0, 4, "wrap");
      begin tick(); tick(); check("wrap_a", mem_a, 32'h00000000); end
    join

    // randomized traffic
    for (int r = 0; r < 60; r++) begin
      repeat ($urandom_range(0, 2)) tick();
      a = $urandom();
      if ($urandom_range(0, 3) == 0) begin
        fetch_req(a, "rnd_if");
      end else begin
        t = types[$urandom_range(0, 7)];
        ls_req(a, t, $urandom(), t[3] ? nbytes(t) + 1 : nbytes(t) + 2, "rnd_ls");
      end
    end

    repeat (4) tick();
    check("if_done_count", 32'(if_done_cnt), 32'(fetch_issued));
    check("ls_fin_count", 32'(ls_fin_cnt), 32'(ls_issued));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
